mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF stage (fetch, read-only) and the MEM stage (load/store).
- Arbitrates between the two ports and latches the winner's request fields.
- Drives the memory handshake and returns the read data or write acknowledge to the winner as a one-cycle valid pulse.
- Each stage stalls while its request is pending and valid is low. Data has priority; a streak counter bounds fetch starvation.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the fetch (IF) port and the
//   load/store (MEM) port. A winner is chosen in IDLE, its request fields are
//   latched onto the memory bus, and the response is returned to that port as a
//   one-cycle valid pulse. Data has priority; a streak counter bounds how many
//   consecutive data grants may pass a waiting fetch.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (read-only)
//   if_rdata/if_valid             fetched word and completion pulse
//   d_req/d_we/d_size/d_addr/
//   d_wdata                       load/store request
//   d_rdata/d_valid               load data and completion pulse
//   m_req/m_we/m_size/m_addr/
//   m_wdata                       memory request bus (all registered)
//   m_ready                       memory accepts when m_req && m_ready
//   m_rvalid/m_rdata              memory response (also acknowledges stores)
//   busy                          high whenever the FSM is not idle
module mem_port_arbiter #(
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic [DWIDTH-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [2:0]        m_size,
  output logic [AWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DWIDTH-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

  localparam logic [3:0] StreakMax = 4'(MAX_DSTREAK);
  localparam logic [2:0] SizeWord  = 3'b010;

  state_e            state_q;
  owner_e            owner_q;
  logic [3:0]        streak_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [2:0]        m_size_q;
  logic [AWIDTH-1:0] m_addr_q;
  logic [DWIDTH-1:0] m_wdata_q;
  logic [DWIDTH-1:0] if_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;
  logic              if_valid_q;
  logic              d_valid_q;
  logic              busy_q;

  // Data wins unless a waiting fetch has already been passed MAX_DSTREAK times.
  logic grant_data;
  assign grant_data = d_req && !(if_req && (streak_q == StreakMax));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_size_q   <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // Valid pulses last exactly the RESP cycle.
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (d_req || if_req) begin
            if (grant_data) begin
              owner_q   <= OwnData;
              m_we_q    <= d_we;
              m_size_q  <= d_size;
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              if (if_req) begin
                streak_q <= (streak_q == StreakMax) ? StreakMax : streak_q + 4'd1;
              end else begin
                streak_q <= '0;
              end
            end else begin
              owner_q   <= OwnFetch;
              m_we_q    <= 1'b0;
              m_size_q  <= SizeWord;
              m_addr_q  <= if_addr;
              m_wdata_q <= '0;
              streak_q  <= '0;
            end
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (m_ready) begin
            m_req_q <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (m_rvalid) begin
            if (owner_q == OwnData) begin
              d_valid_q <= 1'b1;
              // Stores leave the last load data untouched.
              if (!m_we_q) begin
                d_rdata_q <= m_rdata;
              end
            end else if (owner_q == OwnFetch) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= m_rdata;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          owner_q <= OwnNone;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_size   = m_size_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_valid = if_valid_q;
  assign d_valid  = d_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        m_req;
  logic        m_we;
  logic [2:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mem_port_arbiter #(
    .AWIDTH(32),
    .DWIDTH(32),
    .MAX_DSTREAK(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .d_req(d_req),
    .d_we(d_we),
    .d_size(d_size),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .m_req(m_req),
    .m_we(m_we),
    .m_size(m_size),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_ready(m_ready),
    .m_rvalid(m_rvalid),
    .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with the request already driven. Returns in the
  // RESP cycle after checking the whole handshake.
  task automatic serve(input int rdy_dly, input int rv_dly, input logic [31:0] rd,
                       input logic data_own, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic scramble, output int valid_cyc);
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    check("busy_idle", busy, 0);
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      check("m_req_hi", m_req, 1);
      check("m_addr", m_addr, addr);
      check("m_we", m_we, we);
      check("m_size", m_size, size);
      if (we) check("m_wdata", m_wdata, wdata);
      check("busy_req", busy, 1);
      if (scramble && i == 0) begin
        d_addr  = ~d_addr;
        d_wdata = ~d_wdata;
        if_addr = ~if_addr;
      end
      m_ready = (i == rdy_dly);
      tick();
    end
    m_ready = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      check("m_req_wait", m_req, 0);
      check("no_valid_wait", {if_valid, d_valid}, 0);
      check("busy_wait", busy, 1);
      m_rvalid = (i == rv_dly);
      m_rdata  = rd;
      tick();
    end
    m_rvalid  = 1'b0;
    m_rdata   = 32'hFFFF_FFFF;
    valid_cyc = cyc;
    check("d_valid", d_valid, data_own);
    check("if_valid", if_valid, !data_own);
    check("busy_resp", busy, 1);
    if (data_own && !we) check("d_rdata", d_rdata, rd);
    if (!data_own) check("if_rdata", if_rdata, rd);
  endtask

  int vc;
  int last_vc;

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_size   = '0;
    d_addr   = '0;
    d_wdata  = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    tick();
    tick();
    check("rst_m_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_valids", {if_valid, d_valid}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_m_addr", m_addr, 0);
    rst_n = 1'b1;
    tick();

    // Reset while in WAIT; late m_rvalid must be ignored.
    d_req  = 1'b1;
    d_addr = 32'h0000_0040;
    d_size = 3'b010;
    tick();
    check("rw_m_req", m_req, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("rw_in_wait", {m_req, busy}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("rw_async_busy", busy, 0);
    check("rw_async_m_req", m_req, 0);
    d_req = 1'b0;
    tick();
    rst_n    = 1'b1;
    m_rvalid = 1'b1;
    m_rdata  = 32'h0000_0BAD;
    tick();
    m_rvalid = 1'b0;
    check("rw_no_valid", {if_valid, d_valid}, 0);
    check("rw_busy", busy, 0);
    check("rw_m_req_lo", m_req, 0);
    check("rw_d_rdata", d_rdata, 0);
    tick();
    check("rw_idle", {busy, if_valid, d_valid}, 0);

    // Single fetch, minimum latency.
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    serve(0, 0, 32'h0050_0093, 1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 1'b0, vc);
    if_req = 1'b0;
    tick();
    check("fetch_done", {if_valid, busy, m_req}, 0);

    // Load with a one-cycle memory response delay.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_size = 3'b010;
    d_addr = 32'h0000_0400;
    serve(0, 1, 32'h1122_3344, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 1'b0, vc);
    d_req = 1'b0;
    tick();

    // Store with m_ready low for 3 cycles; fields change mid-flight.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_size  = 3'b000;
    d_addr  = 32'h0000_2003;
    d_wdata = 32'h0000_00AB;
    serve(3, 0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h0000_2003, 32'h0000_00AB, 1'b1, vc);
    check("store_keeps_rdata", d_rdata, 32'h1122_3344);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();

    // Contention: data first, then the waiting fetch.
    if_req  = 1'b1;
    if_addr = 32'h0000_0104;
    d_req   = 1'b1;
    d_size  = 3'b010;
    d_addr  = 32'h0000_0500;
    serve(0, 0, 32'h0000_0055, 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 1'b0, vc);
    d_req = 1'b0;
    tick();
    serve(0, 0, 32'h0000_0066, 1'b0, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 1'b0, vc);
    if_req = 1'b0;
    tick();

    // Starvation bound: two rounds of 4 data grants then 1 fetch.
    if_req  = 1'b1;
    if_addr = 32'h0000_0200;
    d_req   = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        d_addr = 32'h0000_3000 + 32'(16 * r + 4 * k);
        serve(0, 0, 32'h0000_D000 + 32'(k), 1'b1, 1'b0, 3'b010,
              32'h0000_3000 + 32'(16 * r + 4 * k), 32'h0, 1'b0, vc);
        tick();
      end
      serve(0, 0, 32'h0000_F00D + 32'(r), 1'b0, 1'b0, 3'b010, 32'h0000_0200, 32'h0,
            1'b0, vc);
      tick();
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    tick();

    // Back-to-back loads, new address presented after each d_valid.
    d_req   = 1'b1;
    last_vc = 0;
    for (int k = 0; k < 3; k++) begin
      d_addr = 32'h0000_0600 + 32'(4 * k);
      serve(0, 0, 32'hA5A5_0000 + 32'(k), 1'b1, 1'b0, 3'b010,
            32'h0000_0600 + 32'(4 * k), 32'h0, 1'b0, vc);
      if (k > 0) check("b2b_spacing", vc - last_vc, 4);
      last_vc = vc;
      if (k == 2) d_req = 1'b0;
      tick();
    end
    check("b2b_no_dup", {busy, m_req}, 0);
    tick();
    check("b2b_idle", {busy, m_req, d_valid, if_valid}, 0);
    check("b2b_last_data", d_rdata, 32'hA5A5_0002);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
